// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, next-PC selection and the IF/ID register.
// Drives the async-read instruction memory and latches its word each edge.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] Instruction,
    output logic [31:0] PCAddress,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] FetchCount
);

    typedef enum logic {
        RESET_HOLD,
        RUN
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;
    if_id_t      ifid_q, ifid_d;

    logic [31:0] pc_plus4;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = BranchTaken | Jump;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ifid_d  = ifid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RESET_HOLD: state_d = RUN;
            RUN: begin
                // Branch is the older instruction, so it outranks jump.
                if (BranchTaken)
                    pc_d = {BranchTarget[31:2], 2'b00};
                else if (Jump)
                    pc_d = {JumpTarget[31:2], 2'b00};
                else if (!Stall)
                    pc_d = pc_plus4;

                if (Flush || redirect) begin
                    ifid_d = '{instr: NOP_WORD, pc4: 32'd0, valid: 1'b0};
                end else if (!Stall) begin
                    ifid_d = '{instr: Instruction, pc4: pc_plus4, valid: 1'b1};
                    cnt_d  = cnt_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= RESET_HOLD;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCAddress        = pc_q;
    assign IFID_Instruction = ifid_q.instr;
    assign IFID_PCPlus4     = ifid_q.pc4;
    assign IFID_Valid       = ifid_q.valid;
    assign FetchCount       = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word i holds i*3.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic [31:0] Instruction;
    logic [31:0] PCAddress;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit dut (
        .Clk(Clk),
        .Reset(Reset),
        .Stall(Stall),
        .Flush(Flush),
        .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget),
        .Jump(Jump),
        .JumpTarget(JumpTarget),
        .Instruction(Instruction),
        .PCAddress(PCAddress),
        .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid),
        .FetchCount(FetchCount)
    );

    always #5 Clk = ~Clk;

    // Async-read memory model: word index times three.
    assign Instruction = (PCAddress >> 2) * 32'd3;

    // Observed bundle {pc, instr, pc4, valid, count}.
    wire [128:0] obs = {PCAddress, IFID_Instruction, IFID_PCPlus4,
                        IFID_Valid, FetchCount};

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", obs,
                     {32'h0, 32'h0, 32'h0, 1'b0, 32'd0});
        end
        Reset = 1'b0;
        step();
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", obs,
                     {32'h0, 32'h0, 32'h0, 1'b0, 32'd0});
        end
    endtask

    task automatic test_sequential();
        step();
        checks++;
        if (obs !== {32'h4, 32'd0, 32'h4, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL seq_fetch0 got=%h exp=%h", obs,
                     {32'h4, 32'd0, 32'h4, 1'b1, 32'd1});
        end
        step();
        checks++;
        if (obs !== {32'h8, 32'd3, 32'h8, 1'b1, 32'd2}) begin
            errors++;
            $display("FAIL seq_fetch1 got=%h exp=%h", obs,
                     {32'h8, 32'd3, 32'h8, 1'b1, 32'd2});
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (obs !== {32'h8, 32'd3, 32'h8, 1'b1, 32'd2}) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h exp=%h", k, obs,
                         {32'h8, 32'd3, 32'h8, 1'b1, 32'd2});
            end
        end
        Stall = 1'b0;
        step();
        checks++;
        if (obs !== {32'hC, 32'd6, 32'hC, 1'b1, 32'd3}) begin
            errors++;
            $display("FAIL stall_release got=%h exp=%h", obs,
                     {32'hC, 32'd6, 32'hC, 1'b1, 32'd3});
        end
    endtask

    task automatic test_branch_jump();
        BranchTaken  = 1'b1;
        BranchTarget = 32'h40;
        Jump         = 1'b1;
        JumpTarget   = 32'h80;
        step();
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        checks++;
        if (obs !== {32'h40, 32'd0, 32'd0, 1'b0, 32'd3}) begin
            errors++;
            $display("FAIL branch_wins got=%h exp=%h", obs,
                     {32'h40, 32'd0, 32'd0, 1'b0, 32'd3});
        end
        step();
        checks++;
        if (obs !== {32'h44, 32'd48, 32'h44, 1'b1, 32'd4}) begin
            errors++;
            $display("FAIL branch_target_fetch got=%h exp=%h", obs,
                     {32'h44, 32'd48, 32'h44, 1'b1, 32'd4});
        end
    endtask

    task automatic test_stall_redirect();
        Stall      = 1'b1;
        Jump       = 1'b1;
        JumpTarget = 32'h23;
        step();
        Stall = 1'b0;
        Jump  = 1'b0;
        checks++;
        if (obs !== {32'h20, 32'd0, 32'd0, 1'b0, 32'd4}) begin
            errors++;
            $display("FAIL stall_jump_align got=%h exp=%h", obs,
                     {32'h20, 32'd0, 32'd0, 1'b0, 32'd4});
        end
        step();
        checks++;
        if (obs !== {32'h24, 32'd24, 32'h24, 1'b1, 32'd5}) begin
            errors++;
            $display("FAIL jump_target_fetch got=%h exp=%h", obs,
                     {32'h24, 32'd24, 32'h24, 1'b1, 32'd5});
        end
    endtask

    task automatic test_flush_stall();
        Flush = 1'b1;
        Stall = 1'b1;
        step();
        Flush = 1'b0;
        Stall = 1'b0;
        checks++;
        if (obs !== {32'h24, 32'd0, 32'd0, 1'b0, 32'd5}) begin
            errors++;
            $display("FAIL flush_stall got=%h exp=%h", obs,
                     {32'h24, 32'd0, 32'd0, 1'b0, 32'd5});
        end
        step();
        checks++;
        if (obs !== {32'h28, 32'd27, 32'h28, 1'b1, 32'd6}) begin
            errors++;
            $display("FAIL flush_resume got=%h exp=%h", obs,
                     {32'h28, 32'd27, 32'h28, 1'b1, 32'd6});
        end
    endtask

    task automatic test_wrap();
        Jump       = 1'b1;
        JumpTarget = 32'hFFFF_FFFC;
        step();
        Jump = 1'b0;
        checks++;
        if (obs !== {32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 32'd6}) begin
            errors++;
            $display("FAIL wrap_jump got=%h exp=%h", obs,
                     {32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 32'd6});
        end
        step();
        checks++;
        if (obs !== {32'h0, 32'hBFFF_FFFD, 32'h0, 1'b1, 32'd7}) begin
            errors++;
            $display("FAIL wrap_pc got=%h exp=%h", obs,
                     {32'h0, 32'hBFFF_FFFD, 32'h0, 1'b1, 32'd7});
        end
        step();
    endtask

    task automatic test_async_reset();
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs,
                     {32'h0, 32'h0, 32'h0, 1'b0, 32'd0});
        end
        step();
        Reset = 1'b0;
        step();
        checks++;
        if (obs !== {32'h0, 32'h0, 32'h0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL rehold got=%h exp=%h", obs,
                     {32'h0, 32'h0, 32'h0, 1'b0, 32'd0});
        end
        step();
        checks++;
        if (obs !== {32'h4, 32'd0, 32'h4, 1'b1, 32'd1}) begin
            errors++;
            $display("FAIL refetch got=%h exp=%h", obs,
                     {32'h4, 32'd0, 32'h4, 1'b1, 32'd1});
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_jump();
        test_stall_redirect();
        test_flush_stall();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front end of the MIPS pipeline. It owns the program counter, drives the fetch address into the asynchronous-read instruction memory, and captures the returned word into the IF/ID pipeline register. It also handles sequential PC+4 advance, branch/jump redirection, hazard stalls and pipeline flushes.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_WORD, 32'h0000_0000: bubble instruction (sll $0,$0,0) written into IF/ID on flush or redirect.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Stall  in  1  hazard stall from the hazard unit; holds PC and IF/ID.
- Flush  in  1  squashes the instruction being latched into IF/ID.
- BranchTaken  in  1  taken-branch redirect, resolved in a later stage.
- BranchTarget  in  32  branch target byte address.
- Jump  in  1  jump redirect from decode.
- JumpTarget  in  32  jump target byte address.
- Instruction  in  32  word returned combinationally by instruction memory for PCAddress.
- PCAddress  out  32  current PC, driven to instruction memory Address.
- IFID_Instruction  out  32  registered fetched instruction.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- FetchCount  out  32  number of valid instructions latched into IF/ID since reset.

## Operation
- PC register: 32 bits. Bits [1:0] are always 0, and targets are stored with [1:0] forced to 00. Arithmetic is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Next-PC priority (highest first): Reset, then BranchTaken (BranchTarget), then Jump (JumpTarget), then Stall (hold), then PC+4.
- Branch beats jump when both are asserted, because the branch is the older instruction.
- A redirect overrides Stall: the PC takes the target even while Stall=1.
- IF/ID update priority (highest first):
  - Reset: all IF/ID outputs = 0.
  - Flush, BranchTaken or Jump: bubble, i.e. IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0.
  - Stall: hold all IF/ID outputs.
  - Otherwise: IFID_Instruction=Instruction, IFID_PCPlus4=PCAddress+4, IFID_Valid=1.
- Flush together with Stall: IF/ID becomes a bubble and the PC holds.
- FetchCount increments by 1 on every edge that loads a valid instruction (the "otherwise" case) and wraps at 2^32.
- State machine, 2 states:
  - RESET_HOLD: entered on reset. Lasts one cycle after reset deasserts; no fetch is latched and the PC stays at RESET_PC. This lets the memory output settle.
  - RUN: moves to RUN on the next edge. Normal operation; the unit stays in RUN until Reset.

## Timing
- Reset values: PCAddress=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0, state=RESET_HOLD.
- Asserting Reset mid-operation clears everything immediately, without waiting for a clock edge.
- PCAddress is a register output. Instruction is sampled on the same edge that advances the PC, so fetch-to-IF/ID latency is 1 cycle.
- Redirect latency: a target asserted during cycle N appears on PCAddress after edge N. The target's instruction is in IF/ID after edge N+1, and IF/ID shows a bubble in between.
- Stall held for k cycles freezes PCAddress and IF/ID for exactly k edges. There is no lost or duplicated fetch.
- All control inputs are sampled only on the rising edge; no combinational path runs from the inputs to the outputs.

## Test plan
- Reset and sequential fetch: release Reset and feed memory[i]=i*3. PCAddress stays 0 for the RESET_HOLD cycle, then steps 0, 4, 8, 12. IF/ID shows (0,4), (3,8), (6,12) with Valid=1, and FetchCount reaches 3.
- Stall: with PC=8, hold Stall for 2 cycles. PCAddress stays 8 and IF/ID stays (3,8) for both edges. After release, IF/ID=(6,12) and PCAddress=12.
- Branch with a simultaneous jump:
  - Stimulus: at PC=12, assert BranchTaken with BranchTarget=0x40, plus Jump with JumpTarget=0x80, for one cycle.
  - Expected: PCAddress=0x40, next IF/ID is a bubble (Valid=0, instr=0). The following edge gives IF/ID=(memory[16], 0x44).
- Redirect during stall, plus alignment: assert Stall=1 and Jump=1 with JumpTarget=0x23. PCAddress becomes 0x20 and IF/ID is a bubble.
- Flush with Stall: assert both for one cycle. IF/ID becomes a bubble, the PC holds, and FetchCount is unchanged.
- Wrap and async reset:
  - Force PC to 0xFFFF_FFFC. The next PCAddress is 0x0000_0000 and IFID_PCPlus4=0.
  - Then pulse Reset between clock edges. All outputs return to their reset values immediately.
